// File: rtl/dm_cache.sv
// Direct-mapped, write-through / no-write-allocate cache with one word per line.
// Writes retire to RAM through a FIFO write buffer that drains ahead of any line fill.
module dm_cache #(
  parameter int INDEX_W    = 4,
  parameter int WBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_ce,
  input  logic        req_we,
  input  logic [3:0]  req_sel,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] req_rdata,
  output logic        stallreq,
  input  logic        flush,
  output logic        ram_ce,
  output logic        ram_we,
  output logic [3:0]  ram_sel,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ready
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 30 - INDEX_W;
  localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] FILL  = 2'd2;

  logic [1:0]         state, state_nxt;
  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [31:0]        data_mem [LINES];
  logic [29:0]        wb_addr  [WBUF_DEPTH];
  logic [3:0]         wb_sel   [WBUF_DEPTH];
  logic [31:0]        wb_data  [WBUF_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]     count;

  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic hit, rd_req, wr_req, wb_empty, wb_full, pop, push, fill_done;
  logic unused_addr_lsb;

  assign unused_addr_lsb = ^req_addr[1:0];
  assign index     = req_addr[INDEX_W+1:2];
  assign tag       = req_addr[31:INDEX_W+2];
  assign hit       = req_ce & valid[index] & (tag_mem[index] == tag);
  assign rd_req    = req_ce & ~req_we;
  assign wr_req    = req_ce & req_we;
  assign wb_empty  = (count == '0);
  assign wb_full   = (count == (PTR_W+1)'(WBUF_DEPTH));
  assign pop       = ~rst & (state == DRAIN) & ram_ready;
  assign fill_done = ~rst & (state == FILL) & ram_ready;
  // A full buffer still takes a write in the cycle its head retires.
  assign push      = ~rst & wr_req & ~(wb_full & ~pop);

  always_comb begin
    stallreq  = 1'b0;
    req_rdata = '0;
    if (!rst && req_ce) begin
      if (req_we) begin
        stallreq = wb_full & ~pop;
      end else begin
        stallreq = ~hit & ~fill_done;
        if (hit)            req_rdata = data_mem[index];
        else if (fill_done) req_rdata = ram_rdata;
      end
    end
  end

  always_comb begin
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_sel   = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (!rst) begin
      if (state == DRAIN) begin
        ram_ce    = 1'b1;
        ram_we    = 1'b1;
        ram_sel   = wb_sel[rd_ptr];
        ram_addr  = {wb_addr[rd_ptr], 2'b00};
        ram_wdata = wb_data[rd_ptr];
      end else if (state == FILL) begin
        ram_ce    = 1'b1;
        ram_sel   = 4'b1111;
        ram_addr  = {req_addr[31:2], 2'b00};
      end
    end
  end

  // Pending writes always go out before a fill so RAM sees program order.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rd_req && !hit && wb_empty) state_nxt = FILL;
        else if (!wb_empty)             state_nxt = DRAIN;
      end
      DRAIN:   if (ram_ready) state_nxt = IDLE;
      FILL:    if (ram_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      valid  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_nxt;
      if (flush)          valid        <= '0;
      else if (fill_done) valid[index] <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + (PTR_W+1)'(1);
      else if (pop && !push) count <= count - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_mem[index]  <= tag;
      data_mem[index] <= ram_rdata;
    end else if (push && hit) begin
      for (int b = 0; b < 4; b++)
        if (req_sel[b]) data_mem[index][8*b +: 8] <= req_wdata[8*b +: 8];
    end
    if (push) begin
      wb_addr[wr_ptr] <= req_addr[31:2];
      wb_sel[wr_ptr]  <= req_sel;
      wb_data[wr_ptr] <= req_wdata;
    end
  end

endmodule

// File: tb/tb_dm_cache.sv
// Bench for dm_cache: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_dm_cache;

  localparam int LINES = 16;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_ce = 1'b0, req_we = 1'b0, flush = 1'b0, ram_ready = 1'b0;
  logic [3:0]  req_sel = '0;
  logic [31:0] req_addr = '0, req_wdata = '0, ram_rdata = '0;
  logic [31:0] req_rdata, ram_addr, ram_wdata;
  logic        stallreq, ram_ce, ram_we;
  logic [3:0]  ram_sel;

  int tests = 0;
  int fails = 0;

  dm_cache #(.INDEX_W(4), .WBUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_ce(req_ce), .req_we(req_we), .req_sel(req_sel),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rdata(req_rdata),
    .stallreq(stallreq), .flush(flush), .ram_ce(ram_ce), .ram_we(ram_we),
    .ram_sel(ram_sel), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ready(ram_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: cache contents keyed by line, write queue, and the RAM
  // transaction currently presented (none / write of queue head / line read).
  typedef struct packed { bit [29:0] a; bit [3:0] s; bit [31:0] d; } wb_t;
  wb_t         m_q[$];
  bit          m_valid [LINES];
  bit [29:0]   m_waddr [LINES];
  bit [31:0]   m_data  [LINES];
  int          m_op = 0;  // 0 none, 1 RAM write, 2 RAM read
  int          m_idx, m_nop;
  bit          m_hit, m_pop, m_fdone, m_acc, m_stall, m_wasempty;
  bit          e_ce, e_we;
  bit [3:0]    e_sel;
  bit [31:0]   e_addr, e_wdata;

  always @(negedge clk) begin
    m_idx = int'(req_addr[31:2]) % LINES;
    m_hit = req_ce && m_valid[m_idx] && (m_waddr[m_idx] == req_addr[31:2]);
    if (rst) begin
      chk("rst.ram_ce", {31'b0, ram_ce}, 0);
      chk("rst.ram_we", {31'b0, ram_we}, 0);
      chk("rst.ram_sel", {28'b0, ram_sel}, 0);
      chk("rst.ram_addr", ram_addr, 0);
      chk("rst.ram_wdata", ram_wdata, 0);
      chk("rst.req_rdata", req_rdata, 0);
      chk("rst.stallreq", {31'b0, stallreq}, 0);
      for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
      m_q.delete();
      m_op = 0;
    end else begin
      e_ce = 0; e_we = 0; e_sel = 0; e_addr = 0; e_wdata = 0;
      if (m_op == 1) begin
        e_ce = 1; e_we = 1; e_sel = m_q[0].s; e_addr = {m_q[0].a, 2'b00}; e_wdata = m_q[0].d;
      end else if (m_op == 2) begin
        e_ce = 1; e_sel = 4'hF; e_addr = {req_addr[31:2], 2'b00};
      end
      m_pop   = (m_op == 1) && ram_ready;
      m_fdone = (m_op == 2) && ram_ready;
      if (!req_ce)     m_stall = 0;
      else if (req_we) m_stall = (m_q.size() == DEPTH) && !m_pop;
      else             m_stall = !(m_hit || m_fdone);
      chk("stallreq", {31'b0, stallreq}, {31'b0, m_stall});
      chk("ram_ce", {31'b0, ram_ce}, {31'b0, e_ce});
      chk("ram_we", {31'b0, ram_we}, {31'b0, e_we});
      chk("ram_sel", {28'b0, ram_sel}, {28'b0, e_sel});
      chk("ram_addr", ram_addr, e_addr);
      chk("ram_wdata", ram_wdata, e_wdata);
      if (req_ce && !req_we && !m_stall)
        chk("req_rdata", req_rdata, m_hit ? m_data[m_idx] : ram_rdata);
      m_acc = req_ce && req_we && !m_stall;
      m_wasempty = (m_q.size() == 0);
      if (m_acc && m_hit)
        for (int b = 0; b < 4; b++)
          if (req_sel[b]) m_data[m_idx][8*b +: 8] = req_wdata[8*b +: 8];
      if (m_fdone) begin
        m_waddr[m_idx] = req_addr[31:2];
        m_data[m_idx]  = ram_rdata;
        m_valid[m_idx] = 1'b1;
      end
      if (flush) for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
      if (m_pop) void'(m_q.pop_front());
      if (m_acc) m_q.push_back('{a: req_addr[31:2], s: req_sel, d: req_wdata});
      m_nop = m_op;
      if (m_op == 1 && m_pop) m_nop = 0;
      else if (m_op == 2 && m_fdone) m_nop = 0;
      else if (m_op == 0) begin
        if (req_ce && !req_we && !m_hit && m_wasempty) m_nop = 2;
        else if (!m_wasempty) m_nop = 1;
      end
      m_op = m_nop;
    end
  end

  task automatic drive(input bit r, input bit c, input bit w, input bit [3:0] s,
                       input bit [31:0] a, input bit [31:0] d, input bit rdy,
                       input bit [31:0] rdv, input bit fl);
    @(posedge clk); #1;
    rst = r; req_ce = c; req_we = w; req_sel = s; req_addr = a; req_wdata = d;
    ram_ready = rdy; ram_rdata = rdv; flush = fl;
    @(negedge clk); #1;
  endtask

  task automatic rd(input bit [31:0] a, input bit rdy = 0, input bit [31:0] rdv = 0, input bit fl = 0);
    drive(0, 1, 0, 4'h0, a, 32'h0, rdy, rdv, fl);
  endtask
  task automatic wr(input bit [31:0] a, input bit [3:0] s, input bit [31:0] d, input bit rdy = 0);
    drive(0, 1, 1, s, a, d, rdy, 32'h0, 0);
  endtask
  task automatic idle(input bit rdy = 0, input bit r = 0);
    drive(r, 0, 0, 4'h0, 32'h0, 32'h0, rdy, 32'h0, 0);
  endtask

  initial begin
    idle(0, 1); idle(0, 1);
    chk("lit.rst_stall", {31'b0, stallreq}, 0);
    chk("lit.rst_ram_ce", {31'b0, ram_ce}, 0);

    // Cold read miss, fill, then hit
    rd(32'h100);
    chk("lit.miss_stall", {31'b0, stallreq}, 1);
    chk("lit.miss_idle_ce", {31'b0, ram_ce}, 0);
    rd(32'h100);
    chk("lit.fill_ce", {31'b0, ram_ce}, 1);
    chk("lit.fill_we", {31'b0, ram_we}, 0);
    chk("lit.fill_addr", ram_addr, 32'h100);
    rd(32'h100, 1, 32'hDEADBEEF);
    chk("lit.fill_rdata", req_rdata, 32'hDEADBEEF);
    chk("lit.fill_stall", {31'b0, stallreq}, 0);
    rd(32'h100);
    chk("lit.hit_rdata", req_rdata, 32'hDEADBEEF);
    chk("lit.hit_ram_ce", {31'b0, ram_ce}, 0);

    // Byte write hit, then write-through to RAM
    wr(32'h100, 4'b0001, 32'h00000011);
    chk("lit.wr_stall", {31'b0, stallreq}, 0);
    rd(32'h100);
    chk("lit.merged", req_rdata, 32'hDEADBE11);
    idle(1);
    chk("lit.drain_addr", ram_addr, 32'h100);
    chk("lit.drain_sel", {28'b0, ram_sel}, 32'h1);
    chk("lit.drain_wdata", ram_wdata, 32'h11);
    idle(0);

    // Fill the buffer; the fifth write waits for the first pop
    for (int i = 0; i < 4; i++) wr(32'h300 + 32'(4*i), 4'hF, 32'hA0 + 32'(i));
    wr(32'h310, 4'hF, 32'hA4);
    chk("lit.full_stall", {31'b0, stallreq}, 1);
    wr(32'h310, 4'hF, 32'hA4);
    wr(32'h310, 4'hF, 32'hA4, 1);
    chk("lit.full_pop_accept", {31'b0, stallreq}, 0);
    chk("lit.full_pop_addr", ram_addr, 32'h300);
    for (int i = 0; i < 12; i++) idle(1);

    // Buffered write miss drains before the read fill
    wr(32'h200, 4'hF, 32'h5);
    rd(32'h200);
    chk("lit.nalloc_stall", {31'b0, stallreq}, 1);
    rd(32'h200, 1);
    chk("lit.order_we", {31'b0, ram_we}, 1);
    chk("lit.order_addr", ram_addr, 32'h200);
    rd(32'h200);
    rd(32'h200, 1, 32'h00000005);
    chk("lit.order_fill_we", {31'b0, ram_we}, 0);
    chk("lit.order_rdata", req_rdata, 32'h5);

    // Conflict misses on index 0, flush on hit and on fill completion
    rd(32'h140); rd(32'h140, 1, 32'h00140140);
    rd(32'h100);
    chk("lit.evict_stall", {31'b0, stallreq}, 1);
    rd(32'h100, 1, 32'h00100100);
    rd(32'h140);
    chk("lit.evict2_stall", {31'b0, stallreq}, 1);
    rd(32'h140, 1, 32'h11111111);
    rd(32'h140, 0, 0, 1);
    chk("lit.flush_hit", req_rdata, 32'h11111111);
    rd(32'h140);
    chk("lit.after_flush", {31'b0, stallreq}, 1);
    rd(32'h140, 1, 32'h22222222, 1);
    chk("lit.flush_fill_rdata", req_rdata, 32'h22222222);
    rd(32'h140);
    chk("lit.flush_fill_noinst", {31'b0, stallreq}, 1);
    rd(32'h140, 1, 32'h33333333);

    // Reset mid-FILL and mid-DRAIN aborts; pending writes discarded
    rd(32'h1C0); rd(32'h1C0);
    drive(1, 1, 0, 4'h0, 32'h1C0, 32'h0, 0, 32'h0, 0);
    chk("lit.rstfill_ce", {31'b0, ram_ce}, 0);
    chk("lit.rstfill_stall", {31'b0, stallreq}, 0);
    idle(1);
    chk("lit.rst_ready_ignored", {31'b0, ram_ce}, 0);
    wr(32'h240, 4'hF, 32'h77); wr(32'h244, 4'hF, 32'h78);
    idle(0);
    chk("lit.pre_rst_drain", {31'b0, ram_ce}, 1);
    idle(0, 1);
    idle(1); idle(1);
    chk("lit.buf_discarded", {31'b0, ram_ce}, 0);
    rd(32'h100);
    chk("lit.post_rst_miss", {31'b0, stallreq}, 1);
    rd(32'h100); rd(32'h100, 1, 32'h0BADF00D);
    idle(0); idle(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dm_cache.md
DM_CACHE -- requirements
Module: dm_cache

Interface
REQ-001 SHALL have parameter INDEX_W, default 4, meaning log2 of line count (2^INDEX_W lines, one 32-bit word per line).
REQ-002 SHALL have parameter WBUF_DEPTH, default 4, meaning write-buffer entries (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_ce  input  1  CPU access valid.
REQ-006 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have port req_sel  input  4  byte enables; bit n covers data[8n+7:8n].
REQ-008 SHALL have port req_addr  input  32  byte address; bits [1:0] ignored.
REQ-009 SHALL have port req_wdata  input  32  write data.
REQ-010 SHALL have port req_rdata  output  32  read data, valid when req_ce=1, req_we=0, stallreq=0.
REQ-011 SHALL have port stallreq  output  1  CPU stall request; CPU holds all req_* stable while 1.
REQ-012 SHALL have port flush  input  1  invalidate all lines.
REQ-013 SHALL have ports ram_ce, ram_we (output 1), ram_sel (output 4), ram_addr, ram_wdata (output 32): RAM request.
REQ-014 SHALL have ports ram_rdata (input 32), ram_ready (input 1): RAM completes current request in the cycle ram_ready=1.

Function
REQ-015 Index = req_addr[INDEX_W+1:2]; tag = req_addr[31:INDEX_W+2]; per line: valid bit, tag, 32-bit data.
REQ-016 Hit = req_ce & valid[index] & (tag[index]==req tag), combinational.
REQ-017 Read hit: req_rdata = line data, stallreq=0 same cycle, no RAM access.
REQ-018 Write policy: write-through, no-write-allocate; write hit updates selected bytes of line at the accepting edge; write miss leaves array unchanged.
REQ-019 Every accepted write (stallreq=0) pushes {addr[31:2], req_sel, req_wdata} into FIFO write buffer at that edge.
REQ-020 Write stallreq=1 iff buffer full and no pop this cycle; full with simultaneous pop accepts push.
REQ-021 FSM states IDLE, DRAIN, FILL; registered state; RAM outputs combinational from state.
REQ-022 IDLE: ram_ce=0; read miss & buffer empty -> FILL; else buffer non-empty -> DRAIN; else stay.
REQ-023 DRAIN: ram_ce=1, ram_we=1, ram_addr={head addr,2'b00}, ram_sel/ram_wdata from head; on ram_ready pop head -> IDLE.
REQ-024 FILL: ram_ce=1, ram_we=0, ram_sel=4'b1111, ram_addr={req_addr[31:2],2'b00}; on ram_ready: line <= {valid=1, tag, ram_rdata}, req_rdata=ram_rdata, stallreq=0 -> IDLE.
REQ-025 Read miss: stallreq=1 in every cycle except the FILL cycle with ram_ready=1; all pending writes drain before the fill (RAM order = program order).
REQ-026 Miss latency with empty buffer: 1 cycle + RAM latency; each buffered write adds its drain time.
REQ-027 req_ce=0 -> stallreq=0; buffer drains in background whenever non-empty and no fill pending.
REQ-028 flush clears all valid bits at the edge; flush coinciding with FILL completion suppresses that line install (data still returned).
REQ-029 Buffer pointers wrap modulo WBUF_DEPTH; full/empty distinguished by an extra pointer bit or a count.

Reset
REQ-030 rst SHALL clear all valid bits, empty the write buffer (pending writes discarded), state <= IDLE.
REQ-031 During and after rst: ram_ce=0, ram_we=0, ram_sel=0, ram_addr=0, ram_wdata=0, req_rdata=0, stallreq=0.
REQ-032 rst mid-DRAIN or mid-FILL SHALL abort the access; ram_ready in the next cycle is ignored.

Verification (INDEX_W=4, WBUF_DEPTH=4)
REQ-033 Read 0x100 after reset -> stallreq=1; next cycle ram_ce=1, ram_we=0, ram_addr=0x100; ram_ready with 0xDEADBEEF -> req_rdata=0xDEADBEEF, stallreq=0; re-read 0x100 -> hit, ram_ce=0.
REQ-034 Then write 0x100 sel=0001 data=0x00000011 -> no stall; read 0x100 -> 0xDEADBE11; RAM sees write addr 0x100 sel 0001 data 0x00000011.
REQ-035 Five back-to-back writes, ram_ready=0 -> writes 1-4 accepted, 5th stallreq=1 until first ram_ready pop, then accepted same cycle.
REQ-036 Write 0x200=0x5 (miss, buffered), then read 0x200 -> RAM write 0x200 completes before RAM read 0x200; no line allocated by the write.
REQ-037 Read 0x100 then 0x140 (same index 0) -> both miss; subsequent read 0x100 misses again; flush then read 0x140 -> miss.
REQ-038 rst asserted in FILL with ram_ready=0 -> next cycle ram_ce=0, stallreq=0, buffer empty; read 0x100 -> miss.
